// File: rtl/uart_tx_bridge.sv
// rtl/uart_tx_bridge.sv - memory-mapped 4-byte FIFO feeding an 8N1 UART transmitter (UART_TX_PARITY_EN adds an even-parity bit)
module uart_tx_bridge #(
  parameter int          CLKS_PER_BIT = 8,
  parameter logic [11:0] IO_ADDR      = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_we,
  input  logic [11:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        tx,
  output logic        busy,
  output logic        full,
  output logic        overflow,
  output logic [2:0]  count
);

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t      state;
  logic [7:0]  mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [7:0]  shift_reg;
  logic [7:0]  baud_cnt;
  logic [2:0]  bit_idx;

  logic push_req;
  logic push_ok;
  logic pop;
  logic baud_done;
  logic unused_bits;

  // Only the low byte of a store is transmitted.
  assign unused_bits = ^wr_data[31:8];

  // A push is judged against the occupancy before any same-edge pop.
  assign push_req  = m_we && (wr_addr == IO_ADDR);
  assign push_ok   = push_req && !full;
  assign pop       = (state == S_IDLE) && (count != 3'd0);
  assign baud_done = (baud_cnt == BAUD_LAST);

  assign full = (count == 3'd4);
  assign busy = (state != S_IDLE) || (count != 3'd0);

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data[7:0];
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)            wr_ptr   <= wr_ptr + 2'd1;
      if (push_req && full)   overflow <= 1'b1;
      if (pop)                rd_ptr   <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Serializer FSM with a registered line output; each bit holds for CLKS_PER_BIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      shift_reg <= 8'd0;
      baud_cnt  <= 8'd0;
      bit_idx   <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= 8'd0;
          bit_idx  <= 3'd0;
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            state     <= S_START;
            tx        <= 1'b0;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_cnt <= 8'd0;
            bit_idx  <= 3'd0;
            tx       <= shift_reg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= 8'd0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= ^shift_reg;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            baud_cnt <= 8'd0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
`endif
        S_STOP: begin
          tx <= 1'b1;
          if (baud_done) begin
            baud_cnt <= 8'd0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        default: begin
          tx       <= 1'b1;
          baud_cnt <= 8'd0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
